// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline blocks: default widths, the NOP
// encoding shown to decode during bubbles, and a log2 helper for sizing.
package mips_pkg;

  localparam int IW_DEF = 32;
  localparam int AW_DEF = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Storage for the fetch queue: DEPTH entries of W bits, one synchronous
// write port and one asynchronous read port. No reset: entries only become
// visible through the occupancy tracking in the parent.
module fetch_queue_mem
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  parameter int PW    = 2
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [PW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [PW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Write the accepted entry into its slot.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Head entry is read combinationally so out_* follows rd_ptr directly.
  always_comb begin
    o_rdata = r_mem[i_raddr];
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO between fetch and the IF/ID register. Fetch can
// keep filling while decode stalls; a taken branch (flush) discards every
// buffered wrong-path entry. Entries are {instr, pc+4}.
//
// Handshake: a push happens on an edge where in_valid & in_ready & ~flush;
// a pop happens where out_valid & out_ready & ~flush. in_ready depends only
// on occupancy (never on out_ready), so a full queue refuses a push even if
// it is popped in the same cycle. out_* hold steady while out_valid & ~out_ready.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IW    = IW_DEF,
  parameter int AW    = AW_DEF,
  localparam int PW   = clog2(DEPTH),
  localparam int LW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_instr,
  input  logic [AW-1:0] in_pc,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_instr,
  output logic [AW-1:0] out_pc,
  output logic [LW-1:0] level
);

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] ONE_LVL  = LW'(1);
  localparam logic [PW-1:0] ONE_PTR  = PW'(1);

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;
  logic [IW+AW-1:0] w_head;

  // Handshake qualification; flush overrides both directions.
  always_comb begin
    in_ready  = (r_level != FULL_LVL);
    out_valid = (r_level != '0);
    w_push    = in_valid & in_ready & ~flush;
    w_pop     = out_valid & out_ready & ~flush;
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .W     (IW + AW),
    .PW    (PW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata ({in_instr, in_pc}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  // Pointer and occupancy tracking; flush returns everything to the empty origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ONE_PTR;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ONE_PTR;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + ONE_LVL;
        2'b01:   r_level <= r_level - ONE_LVL;
        default: r_level <= r_level;
      endcase
    end
  end

  // Gate the head to NOP/0 when empty so stale or unwritten slots never leak.
  always_comb begin
    level = r_level;
    if (out_valid) begin
      out_instr = w_head[IW+AW-1:AW];
      out_pc    = w_head[AW-1:0];
    end else begin
      out_instr = IW'(NOP_INSTR);
      out_pc    = '0;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic. The reference
// is an ordered list of {instr, pc} entries; the driver appends accepted
// words after each edge, a negedge monitor compares the DUT head against it.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int IW    = 32;
  localparam int AW    = 32;
  localparam int LW    = 3;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_instr;
  logic [AW-1:0] in_pc;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic [LW-1:0] level;

  fetch_queue #(.DEPTH(DEPTH), .IW(IW), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .level     (level)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [IW+AW-1:0] exp_q[$];
  int               total;
  int               bad;
  logic             pend_push;
  logic             pend_flush;
  logic [IW+AW-1:0] pend_data;
  logic             mon_en;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Fold the effect of the edge just taken into the reference list.
  task automatic commit();
    if (pend_flush) exp_q.delete();
    else if (pend_push) exp_q.push_back(pend_data);
    pend_push  = 1'b0;
    pend_flush = 1'b0;
  endtask

  // ---------------- driver ----------------
  // One clock of stimulus: inputs are applied just after the edge and the
  // reference decides from its own occupancy whether the word will be taken.
  task automatic cycle(input logic v, input logic [IW-1:0] ins, input logic [AW-1:0] pc,
                       input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    commit();
    in_valid  = v;
    in_instr  = v ? ins : IW'($urandom());
    in_pc     = v ? pc  : AW'($urandom());
    out_ready = rdy;
    flush     = fl;
    pend_flush = fl;
    pend_push  = v && !fl && (exp_q.size() != DEPTH);
    pend_data  = {ins, pc};
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, rdy, 1'b0);
  endtask

  // ---------------- monitor ----------------
  // Compares the visible head/occupancy against the reference between edges
  // and retires the head whenever the DUT completes a pop.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk("level", 64'(level), 64'(exp_q.size()));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(exp_q.size() != DEPTH));
      if (exp_q.size() != 0) begin
        chk("out_instr", 64'(out_instr), 64'(exp_q[0][IW+AW-1:AW]));
        chk("out_pc", 64'(out_pc), 64'(exp_q[0][AW-1:0]));
      end else begin
        chk("out_instr_nop", 64'(out_instr), 64'h0);
        chk("out_pc_zero", 64'(out_pc), 64'h0);
      end
      if (out_valid && out_ready && !flush && exp_q.size() != 0) void'(exp_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [IW-1:0] w;
    total      = 0;
    bad        = 0;
    pend_push  = 1'b0;
    pend_flush = 1'b0;
    pend_data  = '0;
    mon_en     = 1'b0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_instr   = '0;
    in_pc      = '0;
    out_ready  = 1'b0;
    flush      = 1'b0;
    #1;
    chk("reset_level", 64'(level), 64'h0);
    chk("reset_out_valid", 64'(out_valid), 64'h0);
    chk("reset_in_ready", 64'(in_ready), 64'h1);
    chk("reset_out_instr", 64'(out_instr), 64'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;

    // Mid-stream reset with three entries buffered.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h1000_0000 + i, 32'h100 + 4 * i, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    commit();
    in_valid = 1'b0;
    chk("pre_reset_level", 64'(level), 64'h3);
    rst_n = 1'b0;
    #1;
    chk("midrst_level", 64'(level), 64'h0);
    chk("midrst_out_valid", 64'(out_valid), 64'h0);
    chk("midrst_in_ready", 64'(in_ready), 64'h1);
    chk("midrst_out_instr", 64'(out_instr), 64'h0);
    exp_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Streaming with decode always ready.
    cycle(1'b1, 32'h2008_0005, 32'h4, 1'b1, 1'b0);
    cycle(1'b1, 32'h2009_0007, 32'h8, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Fill while stalled; fifth word must be refused, then drain in order.
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'hA000_0000 + i, 32'h200 + 4 * i, 1'b0, 1'b0);
    idle(6, 1'b1);

    // Steady level of two across pointer wrap.
    for (int i = 0; i < 2; i++) cycle(1'b1, 32'hB000_0000 + i, 32'h300 + 4 * i, 1'b0, 1'b0);
    for (int i = 2; i < 12; i++) cycle(1'b1, 32'hB000_0000 + i, 32'h300 + 4 * i, 1'b1, 1'b0);
    idle(4, 1'b1);

    // Flush with a simultaneous push and pop request, then a normal push.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hC000_0000 + i, 32'h400 + 4 * i, 1'b0, 1'b0);
    cycle(1'b1, 32'hDEAD_BEEF, 32'h4FC, 1'b1, 1'b1);
    cycle(1'b1, 32'hC100_0000, 32'h500, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Simultaneous push and pop at DEPTH-1.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hE000_0000 + i, 32'h600 + 4 * i, 1'b0, 1'b0);
    for (int i = 3; i < 6; i++) cycle(1'b1, 32'hE000_0000 + i, 32'h600 + 4 * i, 1'b1, 1'b0);
    idle(5, 1'b1);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      w = IW'($urandom());
      cycle(1'(($urandom_range(0, 3) != 0)), w, AW'($urandom()),
            1'(($urandom_range(0, 2) != 0)), 1'(($urandom_range(0, 15) == 0)));
    end

    // Drain and confirm nothing is left outstanding.
    idle(8, 1'b1);
    @(posedge clk);
    #1;
    commit();
    @(negedge clk);
    #1;
    chk("drain_empty", 64'(exp_q.size()), 64'h0);
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
